line_delay_taps: RTL and testbench



---
 rtl/line_delay_taps_if.sv | 25 ++
 rtl/line_delay_taps.sv | 107 ++++++++++
 tb/tb_line_delay_taps.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_delay_taps_if.sv
// Pixel-side bus of the multi-line delay: accept strobe, frame start, line length,
// input pixel, and the packed delayed-line taps with their validity and error flags.
interface line_delay_taps_if #(
    parameter int WIDTH  = 8,
    parameter int LINES  = 4,
    parameter int ADDR_W = 11
);
    logic                     ce;
    logic                     sof;
    logic [ADDR_W:0]          h_size;
    logic [WIDTH-1:0]         din;
    logic [LINES*WIDTH-1:0]   dout;
    logic [LINES-1:0]         taps_valid;
    logic                     h_size_err;

    modport master (
        output ce, sof, h_size, din,
        input  dout, taps_valid, h_size_err
    );

    modport slave (
        input  ce, sof, h_size, din,
        output dout, taps_valid, h_size_err
    );
endinterface

// File: rtl/line_delay_taps.sv
// Cascade of LINES line memories; tap k is the pixel stream delayed by exactly
// (k+1)*h_size accepted pixels, with per-tap current-frame validity flags.
module line_delay_taps #(
    parameter int WIDTH  = 8,
    parameter int LINES  = 4,
    parameter int ADDR_W = 11
) (
    input logic              clk,
    input logic              rst,
    line_delay_taps_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int LINE_W = $clog2(LINES + 1);
    localparam logic [ADDR_W:0]   H_MIN    = (ADDR_W + 1)'(4);
    localparam logic [ADDR_W:0]   H_MAX    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE      = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   TWO      = (ADDR_W + 1)'(2);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(LINES);
    localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] h);
        if (h < H_MIN) return H_MIN;
        if (h > H_MAX) return H_MAX;
        return h;
    endfunction

    logic [ADDR_W:0]   h_size_r;
    logic [ADDR_W:0]   h_in;
    logic [ADDR_W:0]   h_eff;
    logic              h_bad;
    logic [ADDR_W:0]   addr0;
    logic [ADDR_W:0]   addr1;
    logic [ADDR_W:0]   addr0_cur;
    logic [ADDR_W:0]   addr1_cur;
    logic [ADDR_W:0]   addr0_nxt;
    logic [ADDR_W:0]   addr1_nxt;
    logic [ADDR_W:0]   column;
    logic [LINE_W-1:0] line;
    logic              h_size_err_r;
    logic [WIDTH-1:0]  chain [LINES];

    // A frame start restarts both address counters at 0 on the accepting edge,
    // so the new line length governs the wrap from that very edge.
    always_comb begin
        h_in      = clamp_len(bus.h_size);
        h_bad     = (bus.h_size < H_MIN) || (bus.h_size > H_MAX);
        h_eff     = bus.sof ? h_in : h_size_r;
        addr0_cur = bus.sof ? '0 : addr0;
        addr1_cur = bus.sof ? '0 : addr1;
        addr0_nxt = (addr0_cur == h_eff - ONE) ? '0 : addr0_cur + ONE;
        addr1_nxt = (addr1_cur == h_eff - TWO) ? '0 : addr1_cur + ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr0        <= '0;
            addr1        <= '0;
            column       <= '0;
            line         <= '0;
            h_size_err_r <= 1'b0;
            h_size_r     <= h_in;
        end else if (bus.ce) begin
            addr0 <= addr0_nxt;
            addr1 <= addr1_nxt;
            if (bus.sof) begin
                column   <= ONE;
                line     <= '0;
                h_size_r <= h_in;
                if (h_bad) h_size_err_r <= 1'b1;
            end else if (column == h_size_r) begin
                // Line count ticks on the edge accepting sample h, 2h, ... of the frame
                column <= ONE;
                if (line != LINE_MAX) line <= line + LINE_ONE;
            end else begin
                column <= column + ONE;
            end
        end
    end

    assign chain[0]       = bus.din;
    assign bus.h_size_err = h_size_err_r;

    // Stages >=1 wrap one address earlier to absorb the previous stage's output register
    for (genvar k = 0; k < LINES; k++) begin : g_stage
        logic [WIDTH-1:0]  mem [DEPTH];
        logic [WIDTH-1:0]  tap_p1;
        logic [ADDR_W-1:0] addr;

        assign addr = (k == 0) ? addr0_cur[ADDR_W-1:0] : addr1_cur[ADDR_W-1:0];

        always_ff @(posedge clk) begin
            if (bus.ce && !rst) mem[addr] <= chain[k];
        end

        always_ff @(posedge clk) begin
            if (rst)         tap_p1 <= '0;
            else if (bus.ce) tap_p1 <= mem[addr];
        end

        if (k + 1 < LINES) begin : g_link
            assign chain[k+1] = tap_p1;
        end

        assign bus.dout[k*WIDTH +: WIDTH] = tap_p1;
        assign bus.taps_valid[k]          = (line >= LINE_W'(k + 1));
    end
endmodule

// File: tb/tb_line_delay_taps.sv
// Randomized bench for line_delay_taps: a frame-history model predicts every valid
// tap as the sample (k+1)*h accepted pixels earlier, plus validity and error flags.
module tb_line_delay_taps;
    localparam int WIDTH  = 8;
    localparam int LINES  = 4;
    localparam int ADDR_W = 5;
    localparam int HMAX   = 2 ** ADDR_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_delay_taps_if #(.WIDTH(WIDTH), .LINES(LINES), .ADDR_W(ADDR_W)) bus ();

    line_delay_taps #(.WIDTH(WIDTH), .LINES(LINES), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: frame index of the last accepted sample (-1 = no frame), line length, history
    int               n;
    int               h_m;
    bit               err_m;
    logic [WIDTH-1:0] hist[$];

    function automatic int clamp_m(input int h);
        if (h < 4) return 4;
        if (h > HMAX) return HMAX;
        return h;
    endfunction

    function automatic logic [LINES-1:0] exp_valid();
        logic [LINES-1:0] v;
        v = '0;
        for (int k = 0; k < LINES; k++)
            if (n >= 0 && n >= (k + 1) * h_m) v[k] = 1'b1;
        return v;
    endfunction

    task automatic step(input bit c, input bit s, input logic [WIDTH-1:0] d, input int hs);
        rst        = 1'b0;
        bus.ce     = c;
        bus.sof    = s;
        bus.din    = d;
        bus.h_size = hs[ADDR_W:0];
        @(posedge clk);
        #1;
        if (c) begin
            if (s) begin
                hist.delete();
                n   = 0;
                h_m = clamp_m(hs);
                if (hs < 4 || hs > HMAX) err_m = 1'b1;
                hist.push_back(d);
            end else if (n >= 0) begin
                n++;
                hist.push_back(d);
            end
        end
    endtask

    task automatic do_reset(input int hs);
        rst        = 1'b1;
        bus.ce     = 1'b0;
        bus.sof    = 1'b0;
        bus.din    = '0;
        bus.h_size = hs[ADDR_W:0];
        @(posedge clk);
        #1;
        rst   = 1'b0;
        n     = -1;
        err_m = 1'b0;
        h_m   = clamp_m(hs);
        hist.delete();
    endtask

    task automatic test_reset();
        do_reset(8);
        vectors++;
        if (bus.dout !== '0) begin
            miscompares++;
            $display("FAIL reset_dout got=%h exp=0", bus.dout);
        end
        vectors++;
        if (bus.taps_valid !== '0) begin
            miscompares++;
            $display("FAIL reset_valid got=%b exp=0", bus.taps_valid);
        end
        vectors++;
        if (bus.h_size_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err got=%b exp=0", bus.h_size_err);
        end
    endtask

    task automatic test_basic();
        logic [LINES-1:0] ev;
        do_reset(8);
        for (int i = 0; i < 48; i++) begin
            step(1'b1, i == 0, WIDTH'(i % 256), 8);
            ev = exp_valid();
            vectors++;
            if (bus.taps_valid !== ev) begin
                miscompares++;
                $display("FAIL basic_valid n=%0d got=%b exp=%b", n, bus.taps_valid, ev);
            end
            for (int k = 0; k < LINES; k++) if (ev[k]) begin
                vectors++;
                if (bus.dout[k*WIDTH +: WIDTH] !== hist[n - (k + 1) * h_m]) begin
                    miscompares++;
                    $display("FAIL basic_tap%0d n=%0d got=%0d exp=%0d", k, n,
                             bus.dout[k*WIDTH +: WIDTH], hist[n - (k + 1) * h_m]);
                end
            end
        end
    endtask

    task automatic test_ce_gaps();
        logic [LINES-1:0] ev;
        bit               c;
        do_reset(8);
        step(1'b1, 1'b1, WIDTH'($urandom), 8);
        for (int i = 0; i < 260; i++) begin
            c = ($urandom_range(0, 99) >= 40);
            step(c, 1'b0, WIDTH'($urandom), 8);
            ev = exp_valid();
            vectors++;
            if (bus.taps_valid !== ev) begin
                miscompares++;
                $display("FAIL gaps_valid n=%0d ce=%0d got=%b exp=%b", n, c, bus.taps_valid, ev);
            end
            for (int k = 0; k < LINES; k++) if (ev[k]) begin
                vectors++;
                if (bus.dout[k*WIDTH +: WIDTH] !== hist[n - (k + 1) * h_m]) begin
                    miscompares++;
                    $display("FAIL gaps_tap%0d n=%0d ce=%0d got=%0d exp=%0d", k, n, c,
                             bus.dout[k*WIDTH +: WIDTH], hist[n - (k + 1) * h_m]);
                end
            end
        end
    endtask

    task automatic test_boundary();
        logic [LINES-1:0] ev;
        int               hs;
        for (int t = 0; t < 2; t++) begin
            hs = (t == 0) ? 4 : HMAX;
            do_reset(hs);
            for (int i = 0; i < ((t == 0) ? 40 : 170); i++) begin
                step(1'b1, i == 0, WIDTH'($urandom), hs);
                ev = exp_valid();
                vectors++;
                if (bus.taps_valid !== ev) begin
                    miscompares++;
                    $display("FAIL bound_valid h=%0d n=%0d got=%b exp=%b", hs, n, bus.taps_valid, ev);
                end
                for (int k = 0; k < LINES; k++) if (ev[k]) begin
                    vectors++;
                    if (bus.dout[k*WIDTH +: WIDTH] !== hist[n - (k + 1) * h_m]) begin
                        miscompares++;
                        $display("FAIL bound_tap%0d h=%0d n=%0d got=%0d exp=%0d", k, hs, n,
                                 bus.dout[k*WIDTH +: WIDTH], hist[n - (k + 1) * h_m]);
                    end
                end
            end
        end
    endtask

    task automatic test_clamp();
        logic [LINES-1:0] ev;
        int               len;
        int               seg_h;
        do_reset(8);
        for (int seg = 0; seg < 3; seg++) begin
            seg_h = (seg == 0) ? 2 : (seg == 1) ? 40 : 8;
            len   = (seg == 0) ? 30 : (seg == 1) ? 150 : 20;
            step(1'b1, 1'b1, WIDTH'($urandom), seg_h);
            for (int i = 0; i < len; i++) begin
                // h_size wanders between frame starts; only the sof sample counts
                step(1'b1, 1'b0, WIDTH'($urandom), $urandom_range(0, 63));
                ev = exp_valid();
                vectors++;
                if (bus.h_size_err !== err_m) begin
                    miscompares++;
                    $display("FAIL clamp_err h=%0d n=%0d got=%b exp=%b", seg_h, n, bus.h_size_err, err_m);
                end
                vectors++;
                if (bus.taps_valid !== ev) begin
                    miscompares++;
                    $display("FAIL clamp_valid h=%0d n=%0d got=%b exp=%b", seg_h, n, bus.taps_valid, ev);
                end
                for (int k = 0; k < LINES; k++) if (ev[k]) begin
                    vectors++;
                    if (bus.dout[k*WIDTH +: WIDTH] !== hist[n - (k + 1) * h_m]) begin
                        miscompares++;
                        $display("FAIL clamp_tap%0d h=%0d n=%0d got=%0d exp=%0d", k, seg_h, n,
                                 bus.dout[k*WIDTH +: WIDTH], hist[n - (k + 1) * h_m]);
                    end
                end
            end
        end
        do_reset(8);
        vectors++;
        if (bus.h_size_err !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_err_cleared got=%b exp=0", bus.h_size_err);
        end
    endtask

    task automatic test_reset_midframe();
        logic [LINES-1:0] ev;
        do_reset(8);
        for (int i = 0; i <= 20; i++) step(1'b1, i == 0, WIDTH'($urandom), 8);
        do_reset(8);
        vectors++;
        if (bus.dout !== '0) begin
            miscompares++;
            $display("FAIL midrst_dout got=%h exp=0", bus.dout);
        end
        vectors++;
        if (bus.taps_valid !== '0) begin
            miscompares++;
            $display("FAIL midrst_valid got=%b exp=0", bus.taps_valid);
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b1, i == 0, WIDTH'($urandom), 8);
            ev = exp_valid();
            vectors++;
            if (bus.taps_valid !== ev) begin
                miscompares++;
                $display("FAIL midrst_valid n=%0d got=%b exp=%b", n, bus.taps_valid, ev);
            end
            if (ev[0]) begin
                vectors++;
                if (bus.dout[WIDTH-1:0] !== hist[n - h_m]) begin
                    miscompares++;
                    $display("FAIL midrst_tap0 n=%0d got=%0d exp=%0d", n, bus.dout[WIDTH-1:0], hist[n - h_m]);
                end
            end
        end
    endtask

    task automatic test_sof_midframe();
        logic [LINES-1:0] ev;
        do_reset(8);
        for (int i = 0; i < 50; i++) step(1'b1, i == 0, WIDTH'($urandom), 8);
        step(1'b1, 1'b1, WIDTH'($urandom), 6);
        vectors++;
        if (bus.taps_valid !== '0) begin
            miscompares++;
            $display("FAIL newsof_valid_drop got=%b exp=0", bus.taps_valid);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, WIDTH'($urandom), 6);
            ev = exp_valid();
            vectors++;
            if (bus.taps_valid !== ev) begin
                miscompares++;
                $display("FAIL newsof_valid n=%0d got=%b exp=%b", n, bus.taps_valid, ev);
            end
            for (int k = 0; k < LINES; k++) if (ev[k]) begin
                vectors++;
                if (bus.dout[k*WIDTH +: WIDTH] !== hist[n - (k + 1) * h_m]) begin
                    miscompares++;
                    $display("FAIL newsof_tap%0d n=%0d got=%0d exp=%0d", k, n,
                             bus.dout[k*WIDTH +: WIDTH], hist[n - (k + 1) * h_m]);
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.ce     = 1'b0;
        bus.sof    = 1'b0;
        bus.din    = '0;
        bus.h_size = '0;
        n          = -1;
        h_m        = 4;
        err_m      = 1'b0;
        test_reset();
        test_basic();
        test_ce_gaps();
        test_boundary();
        test_clamp();
        test_reset_midframe();
        test_sof_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
